// File: rtl/overlap_sched.sv
// Block-granular two-channel scheduler feeding a shared overlap datapath.
// Round-robin grant per block, one-deep output register, per-channel sequence tags.
module overlap_sched #(
    parameter int WIDTH     = 65,
    parameter int BLOCK_LEN = 36
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ch0_pcmSample,
    input  logic [WIDTH-1:0] ch1_pcmSample,
    input  logic             ch0_valid,
    input  logic             ch1_valid,
    output logic             ch0_ready,
    output logic             ch1_ready,
    input  logic             ch0_restart,
    input  logic             ch1_restart,
    output logic [1:0]       out_firstSequence,
    output logic [WIDTH-1:0] out_pcmSample,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       grant,
    output logic             busy
);

    localparam int CW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLOCK_LEN - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_count, w_count_nxt;
    logic [1:0]       r_grant, w_grant_nxt;
    logic             r_last, w_last_nxt;
    logic [1:0]       r_first, w_first_nxt;
    logic             r_blk_first, w_blk_first_nxt;
    logic             r_rst_pend, w_rst_pend_nxt;

    logic             w_sel;
    logic             w_pick;
    logic             w_vsel;
    logic             w_own_rst;
    logic             w_rdy;
    logic             w_acc;
    logic             w_done;
    logic [WIDTH-1:0] w_sample;

    always_comb begin
        w_sel     = r_grant[1];
        w_sample  = w_sel ? ch1_pcmSample : ch0_pcmSample;
        w_vsel    = w_sel ? ch1_valid : ch0_valid;
        w_own_rst = w_sel ? ch1_restart : ch0_restart;
        w_rdy     = (r_state == S_BURST) && (!out_valid || out_ready);
        w_acc     = w_rdy && w_vsel;
        w_done    = w_acc && (r_count == LAST);
        ch0_ready = w_rdy && r_grant[0];
        ch1_ready = w_rdy && r_grant[1];
        grant     = r_grant;
        busy      = (r_state == S_BURST);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_blk_first_nxt = r_blk_first;
        w_rst_pend_nxt  = r_rst_pend;
        w_pick          = 1'b0;
        w_first_nxt     = r_first | {ch1_restart, ch0_restart};
        unique case (r_state)
            S_IDLE: begin
                if (ch0_valid || ch1_valid) begin
                    // r_last = 1 means ch1 owned the previous block
                    w_pick = (ch0_valid && ch1_valid) ? !r_last : ch1_valid;
                    w_grant_nxt = w_pick ? 2'b10 : 2'b01;
                    w_blk_first_nxt = w_pick ? (r_first[1] | ch1_restart)
                                             : (r_first[0] | ch0_restart);
                    w_rst_pend_nxt = 1'b0;
                    w_count_nxt = '0;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (w_own_rst) begin
                    w_rst_pend_nxt = 1'b1;
                end
                if (w_acc) begin
                    if (w_done) begin
                        // a restart seen during this burst survives completion
                        w_first_nxt[w_sel] = r_rst_pend | w_own_rst;
                        w_last_nxt  = w_sel;
                        w_grant_nxt = 2'b00;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_grant     <= 2'b00;
            r_last      <= 1'b1;
            r_first     <= 2'b11;
            r_blk_first <= 1'b0;
            r_rst_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_first     <= w_first_nxt;
            r_blk_first <= w_blk_first_nxt;
            r_rst_pend  <= w_rst_pend_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid         <= 1'b0;
            out_pcmSample     <= '0;
            out_firstSequence <= 2'b00;
        end else if (w_acc) begin
            out_valid         <= 1'b1;
            out_pcmSample     <= w_sample;
            out_firstSequence <= {(r_count == '0), r_blk_first};
        end else if (out_ready) begin
            out_valid         <= 1'b0;
        end
    end

endmodule

// File: doc/overlap_sched.md
OVERLAP_SCHED -- requirements
Module: overlap_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 65, bit width of one PCM sample word.
REQ-002 SHALL have parameter BLOCK_LEN, default 36, number of samples per block.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports ch0_pcmSample / ch1_pcmSample, input, WIDTH, sample from channel requester 0 / 1.
REQ-006 SHALL have ports ch0_valid / ch1_valid, input, 1, channel sample offered.
REQ-007 SHALL have ports ch0_ready / ch1_ready, output, 1, channel sample accepted when valid and ready are both high.
REQ-008 SHALL have ports ch0_restart / ch1_restart, input, 1, single-cycle pulse; marks the channel's next block as the first of a new sequence.
REQ-009 SHALL have port out_firstSequence, output, 2, sequence tag to the overlap datapath.
REQ-010 SHALL have port out_pcmSample, output, WIDTH, sample to the overlap datapath.
REQ-011 SHALL have port out_valid, output, 1, registered output word valid.
REQ-012 SHALL have port out_ready, input, 1, overlap datapath accepts the word.
REQ-013 SHALL have port grant, output, 2, one-hot owner of the current burst; 2'b00 when idle.
REQ-014 SHALL have port busy, output, 1, high in BURST state.

Function
REQ-015 SHALL implement two states, IDLE and BURST, sharing one overlap datapath between two channels at block granularity.
REQ-016 SHALL, in IDLE with at least one chN_valid high, grant one channel, load count=0, enter BURST the next cycle; chN_ready is low in IDLE (one-cycle arbitration bubble per block).
REQ-017 SHALL arbitrate round-robin: with both valid, grant the channel not granted last; last_grant resets to ch1, so ch0 wins first contention.
REQ-018 SHALL, in BURST, drive ready only to the granted channel: ready = !out_valid | out_ready; the other channel's ready is 0.
REQ-019 SHALL, on each accepted input, register sample into out_pcmSample and set out_valid the next cycle (latency 1); out_valid clears when out_ready is high and no new sample is accepted.
REQ-020 SHALL sustain one sample per cycle in BURST while out_ready stays high.
REQ-021 SHALL hold out_pcmSample, out_firstSequence and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL increment count (width ceil(log2(BLOCK_LEN))) on each accepted input; on acceptance with count==BLOCK_LEN-1 return to IDLE and update last_grant; no wrap beyond BLOCK_LEN-1.
REQ-023 SHALL set out_firstSequence[1]=1 only for the word with count==0 (first sample of a block).
REQ-024 SHALL set out_firstSequence[0]=1 for every word of a block whose channel first-flag was set when the block was granted.
REQ-025 SHALL keep a per-channel first-flag: set by reset and by chN_restart; cleared when that channel's block completes.
REQ-026 SHALL, for chN_restart during that channel's own burst, leave the current block's tags unchanged and tag the channel's next block (set wins over completion clear in the same cycle).
REQ-027 SHALL ignore chN_valid from the non-granted channel during BURST; its request is served after the burst completes.
REQ-028 SHALL let a stall (out_ready low) hold count, state and grant unchanged.

Reset
REQ-029 SHALL, while reset is low, force state=IDLE, count=0, out_valid=0, out_pcmSample=0, out_firstSequence=2'b00, grant=2'b00, busy=0, ch0_ready=ch1_ready=0, last_grant=ch1, both first-flags=1.
REQ-030 SHALL, on reset mid-burst, discard the partial block; after release the next block of either channel is tagged first (firstSequence[0]=1).

Verification
REQ-031 SHALL cover: after reset, ch0 sends 36 samples 1..36 with out_ready=1 -> outputs 1..36, tag 2'b11 on sample 1, 2'b01 on 2..36, grant=01 throughout, IDLE afterwards.
REQ-032 SHALL cover: both channels continuously valid -> blocks alternate ch0, ch1, ch0; exactly one bubble cycle between blocks; second block of each channel tagged 2'b10 on its first word, 2'b00 elsewhere.
REQ-033 SHALL cover: out_ready low for 5 cycles at sample 10 -> sample 10 held stable on the output, ch0_ready=0, count frozen, no loss or duplication.
REQ-034 SHALL cover: ch1_restart pulsed at ch1's sample 20 -> current block tags unchanged; ch1's next block tagged first (bit0=1).
REQ-035 SHALL cover: reset asserted at ch0 sample 15 -> all outputs at reset values immediately (asynchronous); after release the next block is tagged 2'b11 on its first word.
